// File: rtl/ats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ats_pkg
//  Description : Shared definitions for the ATS eligibility scheduler:
//                default widths, scheduler state encoding and wrap-safe
//                time comparison helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package ats_pkg;

    localparam int c_TIMESTAMP_WIDTH    = 72;
    localparam int c_FRAME_LENGTH_WIDTH = 16;
    localparam int c_BYTE_TIME_FRAC     = 8;

    localparam int          c_STATE_W = 3;
    localparam logic [2:0]  c_S_IDLE  = 3'd0;
    localparam logic [2:0]  c_S_MUL   = 3'd1;
    localparam logic [2:0]  c_S_CALC  = 3'd2;
    localparam logic [2:0]  c_S_CHECK = 3'd3;
    localparam logic [2:0]  c_S_WAIT  = 3'd4;
    localparam logic [2:0]  c_S_ISSUE = 3'd5;

    // a strictly later than b, judged by the sign of the modular difference.
    function automatic logic time_after(input logic [c_TIMESTAMP_WIDTH-1:0] a,
                                        input logic [c_TIMESTAMP_WIDTH-1:0] b);
        logic [c_TIMESTAMP_WIDTH-1:0] d;
        d = a - b;
        return !d[c_TIMESTAMP_WIDTH-1] && (d != '0);
    endfunction

    // a at or later than b (modular difference non-negative).
    function automatic logic time_reached(input logic [c_TIMESTAMP_WIDTH-1:0] a,
                                          input logic [c_TIMESTAMP_WIDTH-1:0] b);
        logic [c_TIMESTAMP_WIDTH-1:0] d;
        d = a - b;
        return !d[c_TIMESTAMP_WIDTH-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ats_token_bucket.sv
`default_nettype none
// ============================================================================
//  Module      : ats_token_bucket
//  Description : Token-bucket arithmetic for one stream. On i_calc it
//                computes and registers SET, BFT and eligibility time; during
//                i_check it evaluates the max-residence test and, on a pass,
//                advances bucket_empty_time.
//  Ports       : clk/rstn          clock, synchronous active-low reset
//                i_calc, i_check   phase strobes from the scheduler FSM
//                i_arrival         latched arrival timestamp
//                i_lrd             length-rate delay of the frame, ns
//                i_empty_to_full   latched EmptyToFullDuration, ns
//                i_max_residence   latched MaxResidenceTime, ns
//                o_et              registered eligibility time
//                o_pass            residence verdict, valid during i_check
//  Revision    : 1.0  initial release
// ============================================================================
module ats_token_bucket
    import ats_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH = c_TIMESTAMP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_calc,
    input  logic                       i_check,
    input  logic [TIMESTAMP_WIDTH-1:0] i_arrival,
    input  logic [TIMESTAMP_WIDTH-1:0] i_lrd,
    input  logic [31:0]                i_empty_to_full,
    input  logic [31:0]                i_max_residence,
    output logic [TIMESTAMP_WIDTH-1:0] o_et,
    output logic                       o_pass
);

    logic [TIMESTAMP_WIDTH-1:0] r_be;
    logic                       r_first;
    logic [TIMESTAMP_WIDTH-1:0] r_set;
    logic [TIMESTAMP_WIDTH-1:0] r_bft;
    logic [TIMESTAMP_WIDTH-1:0] r_et;

    logic [TIMESTAMP_WIDTH-1:0] w_e2f;
    logic [TIMESTAMP_WIDTH-1:0] w_be_eff;
    logic [TIMESTAMP_WIDTH-1:0] w_set;
    logic [TIMESTAMP_WIDTH-1:0] w_bft;
    logic [TIMESTAMP_WIDTH-1:0] w_et;
    logic [TIMESTAMP_WIDTH-1:0] w_residence;
    logic [TIMESTAMP_WIDTH-1:0] w_slack;
    logic [TIMESTAMP_WIDTH-1:0] w_be_next;

    assign w_e2f = TIMESTAMP_WIDTH'(i_empty_to_full);

    // A stream's first frame sees a full bucket: pretend it emptied one
    // full-refill duration before the arrival.
    assign w_be_eff = r_first ? (i_arrival - w_e2f) : r_be;
    assign w_set    = w_be_eff + i_lrd;
    assign w_bft    = w_be_eff + w_e2f;
    assign w_et     = time_after(w_set, i_arrival) ? w_set : i_arrival;

    // ET never precedes arrival, so the plain unsigned difference is safe.
    assign w_residence = r_et - i_arrival;
    assign o_pass      = (w_residence <= TIMESTAMP_WIDTH'(i_max_residence));

    // Tokens beyond a full bucket are lost: when ET is past the full time the
    // empty time moves forward by the overflow.
    assign w_slack   = r_et - r_bft;
    assign w_be_next = w_slack[TIMESTAMP_WIDTH-1] ? r_set : (r_set + w_slack);

    assign o_et = r_et;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_be    <= '0;
            r_first <= 1'b1;
            r_set   <= '0;
            r_bft   <= '0;
            r_et    <= '0;
        end else begin
            if (i_calc) begin
                r_set <= w_set;
                r_bft <= w_bft;
                r_et  <= w_et;
            end
            if (i_check && o_pass) begin
                r_be    <= w_be_next;
                r_first <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ats_eligibility_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ats_eligibility_scheduler
//  Description : Per-stream ATS scheduler. Accepts an arrival timestamp and a
//                frame length together, computes eligibility time, decides
//                pass/discard and issues one release decision per frame once
//                local time reaches eligibility. Keeps pass/drop counters.
//  Ports       : clk/rstn                 clock, synchronous active-low reset
//                current_time             free-running local time, ns
//                s_axis_timestamp_*       arrival time stream
//                s_axis_frame_length_*    frame length stream, bytes
//                cfg_*                    shaping parameters, latched per frame
//                m_axis_release_*         release decision (1 pass, 0 drop)
//                passed_count/dropped_count statistics
//  Revision    : 1.0  initial release
// ============================================================================
module ats_eligibility_scheduler
    import ats_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH    = c_TIMESTAMP_WIDTH,
    parameter int FRAME_LENGTH_WIDTH = c_FRAME_LENGTH_WIDTH,
    parameter int BYTE_TIME_FRAC     = c_BYTE_TIME_FRAC,
    parameter int COUNTER_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [TIMESTAMP_WIDTH-1:0]    current_time,
    input  logic [TIMESTAMP_WIDTH-1:0]    s_axis_timestamp_tdata,
    input  logic                          s_axis_timestamp_tvalid,
    output logic                          s_axis_timestamp_tready,
    input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
    input  logic                          s_axis_frame_length_tvalid,
    output logic                          s_axis_frame_length_tready,
    input  logic [15:0]                   cfg_byte_time,
    input  logic [31:0]                   cfg_empty_to_full,
    input  logic [31:0]                   cfg_max_residence,
    output logic                          m_axis_release_tdata,
    output logic                          m_axis_release_tvalid,
    input  logic                          m_axis_release_tready,
    output logic [COUNTER_WIDTH-1:0]      passed_count,
    output logic [COUNTER_WIDTH-1:0]      dropped_count
);

    localparam int                c_PROD_W = FRAME_LENGTH_WIDTH + 16;
    localparam logic [c_PROD_W-1:0] c_ROUND = c_PROD_W'((1 << BYTE_TIME_FRAC) - 1);

    logic [c_STATE_W-1:0]          r_state;
    logic [c_STATE_W-1:0]          w_state_next;
    logic [TIMESTAMP_WIDTH-1:0]    r_arrival;
    logic [FRAME_LENGTH_WIDTH-1:0] r_length;
    logic [15:0]                   r_byte_time;
    logic [31:0]                   r_e2f;
    logic [31:0]                   r_max_res;
    logic [TIMESTAMP_WIDTH-1:0]    r_lrd;
    logic                          r_pass;
    logic [COUNTER_WIDTH-1:0]      r_passed;
    logic [COUNTER_WIDTH-1:0]      r_dropped;

    logic                          w_accept;
    logic                          w_release_hs;
    logic                          w_calc;
    logic                          w_check;
    logic                          w_bucket_pass;
    logic                          w_eligible;
    logic [TIMESTAMP_WIDTH-1:0]    w_et;
    logic [c_PROD_W-1:0]           w_product;
    logic [c_PROD_W-1:0]           w_lrd_ceil;

    // Both streams must be valid together; rstn gating keeps treadys low
    // throughout reset.
    assign w_accept     = rstn && (r_state == c_S_IDLE) &&
                          s_axis_timestamp_tvalid && s_axis_frame_length_tvalid;
    assign w_release_hs = (r_state == c_S_ISSUE) && m_axis_release_tready;
    assign w_eligible   = time_reached(current_time, w_et);

    // Adding 2^FRAC-1 before the shift rounds the fixed-point product up.
    assign w_product  = c_PROD_W'(r_length) * c_PROD_W'(r_byte_time);
    assign w_lrd_ceil = (w_product + c_ROUND) >> BYTE_TIME_FRAC;

    ats_token_bucket #(
        .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH)
    ) u_bucket (
        .clk             (clk),
        .rstn            (rstn),
        .i_calc          (w_calc),
        .i_check         (w_check),
        .i_arrival       (r_arrival),
        .i_lrd           (r_lrd),
        .i_empty_to_full (r_e2f),
        .i_max_residence (r_max_res),
        .o_et            (w_et),
        .o_pass          (w_bucket_pass)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (w_accept) w_state_next = c_S_MUL;
            c_S_MUL:   w_state_next = c_S_CALC;
            c_S_CALC:  w_state_next = c_S_CHECK;
            // A pass that is already eligible skips WAIT so release lands at T+4.
            c_S_CHECK: w_state_next = (!w_bucket_pass || w_eligible) ? c_S_ISSUE : c_S_WAIT;
            c_S_WAIT:  if (w_eligible) w_state_next = c_S_ISSUE;
            c_S_ISSUE: if (m_axis_release_tready) w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_timestamp_tready    = w_accept;
        s_axis_frame_length_tready = w_accept;
        m_axis_release_tvalid      = (r_state == c_S_ISSUE);
        w_calc                     = (r_state == c_S_CALC);
        w_check                    = (r_state == c_S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_arrival   <= '0;
            r_length    <= '0;
            r_byte_time <= '0;
            r_e2f       <= '0;
            r_max_res   <= '0;
            r_lrd       <= '0;
            r_pass      <= 1'b0;
            r_passed    <= '0;
            r_dropped   <= '0;
        end else begin
            if (w_accept) begin
                r_arrival   <= s_axis_timestamp_tdata;
                r_length    <= s_axis_frame_length_tdata;
                r_byte_time <= cfg_byte_time;
                r_e2f       <= cfg_empty_to_full;
                r_max_res   <= cfg_max_residence;
            end
            if (r_state == c_S_MUL) begin
                r_lrd <= TIMESTAMP_WIDTH'(w_lrd_ceil);
            end
            if (w_check) begin
                r_pass <= w_bucket_pass;
            end
            if (w_release_hs) begin
                if (r_pass) begin
                    r_passed <= r_passed + 1'b1;
                end else begin
                    r_dropped <= r_dropped + 1'b1;
                end
            end
        end
    end

    assign m_axis_release_tdata = r_pass;
    assign passed_count         = r_passed;
    assign dropped_count        = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_ats_eligibility_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ats_eligibility_scheduler
//  Description : Self-checking bench for ats_eligibility_scheduler: directed
//                scenarios followed by randomized frames, compared against a
//                behavioural token-bucket model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ats_eligibility_scheduler;

    logic        clk;
    logic        rstn;
    logic [71:0] current_time;
    logic [71:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic [15:0] fl_data;
    logic        fl_valid;
    logic        fl_ready;
    logic [15:0] cfg_bt;
    logic [31:0] cfg_e2f;
    logic [31:0] cfg_mr;
    logic        rel_data;
    logic        rel_valid;
    logic        rel_ready;
    logic [31:0] passed;
    logic [31:0] dropped;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [71:0] m_be;
    bit          m_first;
    int          n_pass;
    int          n_drop;

    ats_eligibility_scheduler dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .current_time               (current_time),
        .s_axis_timestamp_tdata     (ts_data),
        .s_axis_timestamp_tvalid    (ts_valid),
        .s_axis_timestamp_tready    (ts_ready),
        .s_axis_frame_length_tdata  (fl_data),
        .s_axis_frame_length_tvalid (fl_valid),
        .s_axis_frame_length_tready (fl_ready),
        .cfg_byte_time              (cfg_bt),
        .cfg_empty_to_full          (cfg_e2f),
        .cfg_max_residence          (cfg_mr),
        .m_axis_release_tdata       (rel_data),
        .m_axis_release_tvalid      (rel_valid),
        .m_axis_release_tready      (rel_ready),
        .passed_count               (passed),
        .dropped_count              (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_be    = '0;
        m_first = 1'b1;
        n_pass  = 0;
        n_drop  = 0;
    endtask

    // Token-bucket rules evaluated directly in modular ns arithmetic.
    task automatic model_frame(input logic [71:0] arr, input logic [15:0] len,
                               output bit pass, output logic [71:0] et);
        logic [63:0]        prod;
        logic [71:0]        lrd, be, set, bft, slack;
        logic signed [71:0] ahead;
        prod  = 64'(len) * 64'(cfg_bt);
        lrd   = 72'(prod / 256) + (((prod % 256) != 0) ? 72'd1 : 72'd0);
        be    = m_first ? (arr - 72'(cfg_e2f)) : m_be;
        set   = be + lrd;
        ahead = set - arr;
        et    = (ahead > 0) ? set : arr;
        pass  = ((et - arr) <= 72'(cfg_mr));
        if (pass) begin
            bft     = be + 72'(cfg_e2f);
            slack   = et - bft;
            m_be    = ($signed(slack) < 0) ? set : set + slack;
            m_first = 1'b0;
        end
    endtask

    task automatic do_accept(output bit ok);
        ok = 1'b0;
        ts_valid = 1'b1;
        fl_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (ts_ready && fl_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1;
        ts_valid = 1'b0;
        fl_valid = 1'b0;
        check_eq("accept", ok, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // Full life of one frame; called with the bench positioned at a negedge.
    task automatic run_frame(input logic [71:0] arr, input logic [15:0] len,
                             input logic [71:0] ct, input int bp);
        bit                 exp_pass;
        logic [71:0]        exp_et;
        bit                 ok;
        bit                 seen;
        int                 lat;
        logic signed [71:0] d;
        model_frame(arr, len, exp_pass, exp_et);
        current_time = ct;
        ts_data      = arr;
        fl_data      = len;
        do_accept(ok);
        d = ct - exp_et;
        if (exp_pass && (d < 0)) begin
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rel_valid) seen = 1'b1;
            end
            check_eq("wait_hold", seen, 0);
            current_time = exp_et - 72'd1;
            @(negedge clk);
            check_eq("wait_early", rel_valid, 0);
            current_time = exp_et;
            @(negedge clk);
            check_eq("wait_release", rel_valid, 1);
        end else begin
            lat = 0;
            for (int i = 1; i <= 8 && lat == 0; i++) begin
                @(negedge clk);
                if (rel_valid) lat = i;
            end
            check_eq("latency", lat, 4);
        end
        check_eq("tdata", rel_data, exp_pass);
        for (int k = 0; k < bp; k++) begin
            ts_valid = 1'b1;
            fl_valid = 1'b1;
            #1;
            check_eq("bp_tready", {ts_ready, fl_ready}, 0);
            @(negedge clk);
            check_eq("bp_tvalid", rel_valid, 1);
            check_eq("bp_tdata", rel_data, exp_pass);
            check_eq("bp_count", 72'(passed) + 72'(dropped), n_pass + n_drop);
        end
        ts_valid  = 1'b0;
        fl_valid  = 1'b0;
        rel_ready = 1'b1;
        @(posedge clk);
        #1;
        rel_ready = 1'b0;
        if (exp_pass) n_pass++; else n_drop++;
        @(negedge clk);
        check_eq("passed_count", passed, n_pass);
        check_eq("dropped_count", dropped, n_drop);
        check_eq("tvalid_clear", rel_valid, 0);
    endtask

    initial begin
        bit          ok;
        bit          seen;
        logic [71:0] arr;
        logic [71:0] ct;
        logic [15:0] len;

        rstn = 1'b0; current_time = '0; ts_data = '0; ts_valid = 1'b0;
        fl_data = '0; fl_valid = 1'b0; rel_ready = 1'b0;
        cfg_bt = 16'h0800; cfg_e2f = 32'd1600; cfg_mr = 32'd10000;
        model_reset();

        // Reset state, including treadys held low with both valids high
        repeat (3) @(negedge clk);
        ts_valid = 1'b1;
        fl_valid = 1'b1;
        #1;
        check_eq("rst_tready", {ts_ready, fl_ready}, 0);
        check_eq("rst_tvalid", rel_valid, 0);
        check_eq("rst_tdata", rel_data, 0);
        check_eq("rst_counts", {passed, dropped}, 0);
        ts_valid = 1'b0;
        fl_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // First frame, then two more at the same arrival with time held
        run_frame(72'd1000, 16'd100, 72'd1200, 0);
        run_frame(72'd1000, 16'd100, 72'd1000, 0);
        run_frame(72'd1000, 16'd100, 72'd1000, 0);

        // Residence limit exceeded
        cfg_mr = 32'd500;
        run_frame(72'd1000, 16'd100, 72'd1000, 0);
        cfg_mr = 32'd10000;

        // Timestamp arrives alone for 5 cycles
        ts_data  = 72'd1000;
        ts_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("ts_alone_tready", {ts_ready, fl_ready}, 0);
            @(negedge clk);
        end
        run_frame(72'd1000, 16'd100, 72'd3000, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rel_valid) seen = 1'b1;
        end
        check_eq("single_release", seen, 0);

        // Release backpressure
        run_frame(72'd3000, 16'd100, 72'd4000, 10);

        // Reset while waiting for eligibility
        current_time = '0;
        ts_data      = 72'd1000;
        fl_data      = 16'd100;
        do_accept(ok);
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rel_valid) seen = 1'b1;
        end
        check_eq("rst_mid_release", seen, 0);
        check_eq("rst_mid_counts", {passed, dropped}, 0);
        run_frame(72'd5000, 16'd100, 72'd5000, 0);
        run_frame(72'd5000, 16'd100, 72'd5000, 0);

        // First frame just before the timestamp wrap; eligibility lands after it
        pulse_reset();
        @(negedge clk);
        arr = 72'd0 - 72'd100;
        run_frame(arr, 16'd300, arr - 72'd50, 0);

        // Randomized frames and configuration
        arr = 72'd1_000_000;
        for (int f = 0; f < 40; f++) begin
            cfg_bt  = 16'($urandom_range(0, 16'hffff));
            cfg_e2f = $urandom_range(0, 100000);
            cfg_mr  = $urandom_range(0, 60000);
            len     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
            arr     = arr + 72'($urandom_range(0, 20000));
            ct      = arr - 72'd200 + 72'($urandom_range(0, 5000));
            run_frame(arr, len, ct, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ats_eligibility_scheduler.md
Name: ats_eligibility_scheduler

Overview:
- Per-stream Asynchronous Traffic Shaping (802.1Qcr token-bucket) scheduler sitting behind separate_timestamp.
- Consumes one arrival timestamp plus one frame length per frame and computes the frame's eligibility time.
- Decides pass or discard (max-residence check), then issues a release decision to the frame buffer once the local time reaches eligibility.
- Maintains bucket state and pass/drop statistics.

Parameters:
- TIMESTAMP_WIDTH, 72, width of timestamps in ns; all time arithmetic is modulo 2^TIMESTAMP_WIDTH.
- FRAME_LENGTH_WIDTH, 16, frame length in bytes.
- BYTE_TIME_FRAC, 8, fractional bits of cfg_byte_time.
- COUNTER_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- current_time  in  TIMESTAMP_WIDTH  free-running local time, ns
- s_axis_timestamp_tdata  in  TIMESTAMP_WIDTH  arrival time
- s_axis_timestamp_tvalid  in  1
- s_axis_timestamp_tready  out  1
- s_axis_frame_length_tdata  in  FRAME_LENGTH_WIDTH  length in bytes
- s_axis_frame_length_tvalid  in  1
- s_axis_frame_length_tready  out  1
- cfg_byte_time  in  16  ns per byte, unsigned fixed-point, BYTE_TIME_FRAC fractional bits
- cfg_empty_to_full  in  32  bucket EmptyToFullDuration, ns
- cfg_max_residence  in  32  MaxResidenceTime, ns
- m_axis_release_tdata  in/out: out  1  1 = pass, 0 = discard
- m_axis_release_tvalid  out  1
- m_axis_release_tready  in  1
- passed_count  out  COUNTER_WIDTH  frames passed
- dropped_count  out  COUNTER_WIDTH  frames discarded

Behaviour:
- Reset (rstn low at posedge): state IDLE, all tready/tvalid 0, release tdata 0, counters 0, bucket_empty_time 0, first_frame flag set. Reset mid-frame discards the in-flight frame; no release is issued for it.
- Input handshake:
  - In IDLE, both s_*_tready = 1 only when both s_*_tvalid = 1, so both streams are consumed in the same cycle T.
  - A single valid stream waits with no consumption.
  - cfg_* are latched at T; later changes do not affect this frame.
- States:
  - IDLE -> MUL: on the handshake.
  - MUL (T+1): LRD = ceil(length * cfg_byte_time / 2^BYTE_TIME_FRAC), registered.
  - CALC (T+2):
    - If first_frame, BE = arrival - empty_to_full.
    - SET = BE + LRD; BFT = BE + empty_to_full; ET = arrival if (SET - arrival) is negative or zero, else SET.
  - CHECK (T+3):
    - Pass if (ET - arrival) <= max_residence, unsigned difference. Then:
      - bucket_empty_time = SET when (ET - BFT) is negative; otherwise SET + (ET - BFT).
      - Clear first_frame; go to WAIT.
    - Otherwise discard: bucket and first_frame unchanged; go to ISSUE with tdata 0.
  - WAIT: stay until (current_time - ET) is non-negative in signed modulo arithmetic, then go to ISSUE. Earliest pass release: tvalid at T+4.
  - ISSUE:
    - tvalid = 1, tdata held stable until tready.
    - On the handshake: increment passed_count or dropped_count (wrapping), then go to IDLE.
    - The next input can be accepted in the cycle after the release handshake.
- Time comparisons: wrap-safe signed difference (MSB of the modular subtraction); valid while |difference| < 2^(TIMESTAMP_WIDTH-1).
- Zero-length frame: LRD = 0, ET = max(arrival, BE).

Decomposition:
- Shared package ats_pkg:
  - state encoding;
  - time_after(a, b) signed-difference helper;
  - defaults for TIMESTAMP_WIDTH, FRAME_LENGTH_WIDTH, BYTE_TIME_FRAC.
- One natural sub-module, ats_token_bucket: combinational and registered CALC/CHECK arithmetic plus bucket_empty_time state.
- The top level holds the FSM, handshakes and counters.

Test Plan:
Common config: cfg_byte_time = 0x0800 (8 ns/B), empty_to_full = 1600, max_residence = 10000, length 100 B (LRD = 800).
- First frame, arrival 1000, current_time 1200 -> pass, tvalid at T+4, BE becomes 200, passed_count = 1.
- Two more frames, arrival 1000, current_time held at 1000:
  - frame 2 -> pass immediately, BE = 1000;
  - frame 3 -> ET = 1800, tvalid stays 0 until current_time reaches 1800, then pass; BE = 1800.
- max_residence = 500, frame arrival 1000 -> ET 2600 exceeds 1500 -> tdata 0 at T+4, dropped_count = 1, BE stays 1800.
- Timestamp valid 5 cycles before length valid -> both treadys low until the length arrives; both consumed in the same cycle; exactly one release issued.
- m_axis_release_tready low for 10 cycles -> tvalid and tdata stable, no new input accepted, counter increments only on the handshake.
- Arrival 2^72 - 100, first frame, current_time wraps to 50 -> eligibility reached correctly across the wrap, pass.
- rstn pulsed low during WAIT -> no release issued, counters 0, next frame treated as first_frame.
